// File: rtl/uart_tx_fifo_param_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM states, parity modes
// and the counter-width helper used to size the baud and bit counters.
package uart_tx_fifo_param_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   // Width of a counter that must hold 0..n-1; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_tx_fifo_param_if.sv
// Producer-side bus of the UART transmitter: write strobe/data in, FIFO status
// and serial line out. The master drives writes, the slave is the transmitter.
interface uart_tx_fifo_param_if #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic                 i_Tx_DV;
   logic [DATA_BITS-1:0] i_Tx_Byte;
   logic                 o_Ready;
   logic                 o_Overflow;
   logic [CNT_W-1:0]     o_Fifo_Count;
   logic                 o_Tx_Active;
   logic                 o_Tx_Done;
   logic                 o_Tx_Serial;

   modport master (
      output i_Tx_DV, i_Tx_Byte,
      input  o_Ready, o_Overflow, o_Fifo_Count, o_Tx_Active, o_Tx_Done, o_Tx_Serial
   );

   modport slave (
      input  i_Tx_DV, i_Tx_Byte,
      output o_Ready, o_Overflow, o_Fifo_Count, o_Tx_Active, o_Tx_Done, o_Tx_Serial
   );
endinterface

// File: rtl/uart_tx_fifo_param_sync_fifo.sv
// Show-ahead synchronous FIFO: registered count/ready, overflow pulse one cycle
// after a dropped write; full is judged on the registered count, before any pop.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           wdata_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       empty_o,
   output logic                       ready_o,
   output logic                       overflow_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, rd_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ready_q, ovf_q;
   logic             full, do_push, do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign do_push = push_i && !full;
   assign do_pop  = pop_i && !empty_o;
   assign count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         ready_q <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         if (do_push) wr_q <= wr_q + PTR_W'(1);
         if (do_pop)  rd_q <= rd_q + PTR_W'(1);
         count_q <= count_d;
         ready_q <= (count_d != CNT_W'(DEPTH));
         ovf_q   <= push_i && full;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= wdata_i;
   end

   assign rdata_o    = mem_q[rd_q];
   assign count_o    = count_q;
   assign empty_o    = (count_q == '0);
   assign ready_o    = ready_q;
   assign overflow_o = ovf_q;

endmodule

// File: rtl/uart_tx_fifo_param.sv
// UART transmitter fed by a FIFO: push at N into an empty FIFO drives START from N+2;
// frames run back to back while words remain, writes while full are dropped.
module uart_tx_fifo_param
   import uart_tx_fifo_param_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                 clk_50,
   input  logic                 rst,
   uart_tx_fifo_param_if.slave  bus
);
   localparam int BAUD_W = cnt_w(CLKS_PER_BIT);
   localparam int BIT_W  = cnt_w(DATA_BITS);
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam logic PAR_INIT = (PARITY == PARITY_ODD);

   tx_state_e            state_q, state_d;
   logic [BAUD_W-1:0]    baud_q, baud_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 pop, fifo_empty, fifo_ready, fifo_ovf;
   logic [DATA_BITS-1:0] fifo_rdata;
   logic [CNT_W-1:0]     fifo_count;
   logic                 baud_end, last_data, last_stop;
   logic                 tx_serial, tx_active, tx_done;

   sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i      (clk_50),
      .rst_i      (rst),
      .push_i     (bus.i_Tx_DV),
      .wdata_i    (bus.i_Tx_Byte),
      .pop_i      (pop),
      .rdata_o    (fifo_rdata),
      .count_o    (fifo_count),
      .empty_o    (fifo_empty),
      .ready_o    (fifo_ready),
      .overflow_o (fifo_ovf)
   );

   assign baud_end  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
   assign last_data = (bit_q == BIT_W'(DATA_BITS - 1));
   assign last_stop = baud_end && (bit_q == BIT_W'(STOP_BITS - 1));

   always_ff @(posedge clk_50) begin
      if (rst) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
      end
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_end ? '0 : baud_q + BAUD_W'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      pop     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            baud_d = '0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = ST_START;
               shift_d = fifo_rdata;
               par_d   = PAR_INIT;
               bit_d   = '0;
            end
         end
         ST_START: if (baud_end) state_d = ST_DATA;
         ST_DATA: if (baud_end) begin
            // Parity accumulates each bit as it leaves the shifter.
            shift_d = shift_q >> 1;
            par_d   = par_q ^ shift_q[0];
            bit_d   = bit_q + BIT_W'(1);
            if (last_data) begin
               bit_d   = '0;
               state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: if (baud_end) state_d = ST_STOP;
         ST_STOP: if (baud_end) begin
            bit_d = bit_q + BIT_W'(1);
            if (last_stop) begin
               bit_d   = '0;
               state_d = ST_IDLE;
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  state_d = ST_START;
                  shift_d = fifo_rdata;
                  par_d   = PAR_INIT;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      tx_serial = 1'b1;
      tx_active = 1'b1;
      tx_done   = 1'b0;
      unique case (state_q)
         ST_IDLE:   tx_active = 1'b0;
         ST_START:  tx_serial = 1'b0;
         ST_DATA:   tx_serial = shift_q[0];
         ST_PARITY: tx_serial = par_q;
         ST_STOP:   tx_done   = last_stop;
         default:   tx_active = 1'b0;
      endcase
   end

   assign bus.o_Tx_Serial  = tx_serial;
   assign bus.o_Tx_Active  = tx_active;
   assign bus.o_Tx_Done    = tx_done;
   assign bus.o_Ready      = fifo_ready;
   assign bus.o_Overflow   = fifo_ovf;
   assign bus.o_Fifo_Count = fifo_count;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Three transmitter configurations checked every cycle against a queue-based frame model,
// plus hand-computed waveform points for reset, 8N1, parity, overflow, chaining and abort.
module tb_uart_tx_fifo_param;
   localparam int LOGN = 8192;

   typedef struct packed {
      logic       ser;
      logic       done;
      logic       act;
      logic       rdy;
      logic       ovf;
      logic [4:0] cnt;
   } smp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       dv  [3];
   logic [8:0] dat [3];
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   smp_t       lg [3][LOGN];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int lane, input int at,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s lane=%0d cycle=%0d actual=%0h expected=%0h", nm, lane, at, act, exp);
      end
   endtask

   // Number of logged cycles in [a,b] where the chosen output was 1.
   function automatic int cnt_sel(input int g, input int sel, input int a, input int b);
      int s = 0;
      for (int k = a; k <= b; k++) begin
         if (k >= 0 && k < LOGN) begin
            case (sel)
               0: s += int'(lg[g][k].ser);
               1: s += int'(lg[g][k].done);
               2: s += int'(lg[g][k].act);
               default: s += int'(lg[g][k].ovf);
            endcase
         end
      end
      return s;
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   for (genvar g = 0; g < 3; g++) begin : lane
      localparam int CPB = (g == 2) ? 2 : 4;
      localparam int DB  = (g == 0) ? 8 : (g == 1) ? 9 : 5;
      localparam int PAR = (g == 0) ? 0 : (g == 1) ? 2 : 1;
      localparam int STB = (g == 1) ? 2 : 1;
      localparam int DEP = (g == 0) ? 16 : (g == 1) ? 8 : 2;

      uart_tx_fifo_param_if #(.DATA_BITS(DB), .FIFO_DEPTH(DEP)) bus ();
      assign bus.i_Tx_DV   = dv[g];
      assign bus.i_Tx_Byte = dat[g][DB-1:0];

      uart_tx_fifo_param #(
         .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(PAR),
         .STOP_BITS(STB), .FIFO_DEPTH(DEP)
      ) dut (
         .clk_50 (clk),
         .rst    (rst),
         .bus    (bus)
      );

      // mq: words waiting; fr: remaining cycles of the current frame as {line, done}.
      logic [8:0] mq[$];
      logic [1:0] fr[$];
      logic       eovf = 1'b0;

      always @(negedge clk) begin : model
         logic [8:0] w;
         int         ones;
         bit         full;
         logic       v;
         chk("ser",   g, cyc, bus.o_Tx_Serial, (fr.size() != 0) ? fr[0][1] : 1'b1);
         chk("done",  g, cyc, bus.o_Tx_Done,   (fr.size() != 0) ? fr[0][0] : 1'b0);
         chk("act",   g, cyc, bus.o_Tx_Active, fr.size() != 0);
         chk("count", g, cyc, bus.o_Fifo_Count, mq.size());
         chk("ready", g, cyc, bus.o_Ready,     mq.size() < DEP);
         chk("ovf",   g, cyc, bus.o_Overflow,  eovf);
         if (cyc < LOGN)
            lg[g][cyc] = '{ser: bus.o_Tx_Serial, done: bus.o_Tx_Done, act: bus.o_Tx_Active,
                           rdy: bus.o_Ready, ovf: bus.o_Overflow, cnt: 5'(bus.o_Fifo_Count)};
         if (rst) begin
            mq.delete();
            fr.delete();
            eovf = 1'b0;
         end else begin
            full = (mq.size() >= DEP);
            eovf = dv[g] && full;
            if (fr.size() > 1) begin
               void'(fr.pop_front());
            end else begin
               fr.delete();
               if (mq.size() != 0) begin
                  w    = mq.pop_front();
                  ones = $countones(w[DB-1:0]);
                  for (int k = 0; k < 1 + DB + ((PAR != 0) ? 1 : 0) + STB; k++) begin
                     if (k == 0)                        v = 1'b0;
                     else if (k <= DB)                  v = w[k-1];
                     else if (PAR != 0 && k == DB + 1)  v = (PAR == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
                     else                               v = 1'b1;
                     for (int c = 0; c < CPB; c++) fr.push_back({v, 1'b0});
                  end
                  fr[fr.size()-1][0] = 1'b1;
               end
            end
            if (dv[g] && !full) mq.push_back(dat[g]);
         end
      end
   end

   initial begin
      int n, m, p, q;
      int rates [4] = '{3, 40, 95, 10};
      logic [9:0] pat_a5 = 10'b11_0100_1010;
      logic [3:0] win;

      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         dv[i]  = 1'b0;
         dat[i] = '0;
      end
      step(3);
      rst = 1'b0;

      // Reset state and long idle.
      n = cyc;
      step(100);
      for (int g = 0; g < 3; g++) begin
         chk("idle_ser",  g, n, cnt_sel(g, 0, n, n + 99), 100);
         chk("idle_done", g, n, cnt_sel(g, 1, n, n + 99), 0);
         chk("idle_act",  g, n, cnt_sel(g, 2, n, n + 99), 0);
         chk("rst_cnt",   g, n, lg[g][n].cnt, 0);
         chk("rst_rdy",   g, n, lg[g][n].rdy, 1);
      end

      // 0xA5 on 8N1, 0x07 on 9E2, 0x07 on 5O1 (2 clocks per bit).
      n = cyc;
      for (int i = 0; i < 3; i++) dv[i] = 1'b1;
      dat[0] = 9'h0A5;
      dat[1] = 9'h007;
      dat[2] = 9'h007;
      step(1);
      for (int i = 0; i < 3; i++) dv[i] = 1'b0;
      step(70);
      chk("a5_pre_line", 0, n + 1, lg[0][n+1].ser, 1);
      for (int i = 0; i < 10; i++) begin
         for (int j = 0; j < 4; j++) win[j] = lg[0][n + 2 + 4*i + j].ser;
         chk("a5_bit", 0, i, win, {4{pat_a5[i]}});
      end
      chk("a5_done_at",  0, n + 41, lg[0][n+41].done, 1);
      chk("a5_done_cnt", 0, n,      cnt_sel(0, 1, n, n + 70), 1);
      chk("a5_act_pre",  0, n + 1,  lg[0][n+1].act, 0);
      chk("a5_act_on",   0, n + 2,  lg[0][n+2].act, 1);
      chk("a5_act_end",  0, n + 41, lg[0][n+41].act, 1);
      chk("a5_act_off",  0, n + 42, lg[0][n+42].act, 0);
      chk("even_par",    1, n + 42, cnt_sel(1, 0, n + 42, n + 45), 4);
      chk("stop2_high",  1, n + 46, cnt_sel(1, 0, n + 46, n + 53), 8);
      chk("stop2_done",  1, n + 53, lg[1][n+53].done, 1);
      chk("stop2_dcnt",  1, n,      cnt_sel(1, 1, n, n + 70), 1);
      chk("odd_par",     2, n + 14, cnt_sel(2, 0, n + 14, n + 15), 0);
      chk("odd_done",    2, n + 17, lg[2][n+17].done, 1);

      // Back-to-back frames.
      m = cyc;
      dv[0]  = 1'b1;
      dat[0] = 9'h055;
      step(1);
      dat[0] = 9'h00F;
      step(1);
      dv[0] = 1'b0;
      step(90);
      chk("b2b_done1", 0, m + 41, lg[0][m+41].done, 1);
      chk("b2b_done2", 0, m + 81, lg[0][m+81].done, 1);
      chk("b2b_dcnt",  0, m,      cnt_sel(0, 1, m, m + 90), 2);
      chk("b2b_start", 0, m + 42, {lg[0][m+42].ser, lg[0][m+42].act}, 2'b01);

      // 18 consecutive pushes into the 16-deep FIFO.
      p = cyc;
      dv[0] = 1'b1;
      for (int k = 0; k < 18; k++) begin
         dat[0] = 9'($urandom_range(0, 255));
         step(1);
      end
      dv[0] = 1'b0;
      step(700);
      chk("full_rdy_pre", 0, p + 16, lg[0][p+16].rdy, 1);
      chk("full_rdy",     0, p + 17, lg[0][p+17].rdy, 0);
      chk("full_cnt",     0, p + 17, lg[0][p+17].cnt, 16);
      chk("ovf_at",       0, p + 18, lg[0][p+18].ovf, 1);
      chk("ovf_cnt",      0, p,      cnt_sel(0, 3, p, p + 30), 1);
      chk("full_frames",  0, p,      cnt_sel(0, 1, p, p + 717), 17);

      // Reset during DATA bit 3 with five words waiting.
      q = cyc;
      dv[0] = 1'b1;
      for (int k = 0; k < 6; k++) begin
         dat[0] = 9'($urandom_range(0, 255));
         step(1);
      end
      dv[0] = 1'b0;
      step(13);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(50);
      chk("abort_cnt_pre", 0, q + 19, lg[0][q+19].cnt, 5);
      chk("abort_act_pre", 0, q + 19, lg[0][q+19].act, 1);
      chk("abort_line",    0, q + 20, lg[0][q+20].ser, 1);
      chk("abort_cnt",     0, q + 20, lg[0][q+20].cnt, 0);
      chk("abort_act",     0, q + 20, lg[0][q+20].act, 0);
      chk("abort_no_done", 0, q,      cnt_sel(0, 1, q + 18, q + 69), 0);

      // Random traffic with varying load and rare resets.
      for (int t = 0; t < 4000; t++) begin
         for (int i = 0; i < 3; i++) begin
            dv[i]  = ($urandom_range(0, 99) < rates[t / 1000]);
            dat[i] = 9'($urandom_range(0, 511));
         end
         rst = ($urandom_range(0, 1999) == 0);
         step(1);
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) dv[i] = 1'b0;
      step(800);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
